// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Round-robin arbiter that shares one two-stage ALU between NREQ requesters.
// One operation is accepted per cycle through a valid/ready handshake and
// driven straight onto the ALU input port. The identity of the issuing
// requester travels alongside the operation in a small tag pipeline that
// matches the ALU latency. When the ALU result emerges, it is steered back to
// that requester as a one-cycle strobe.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous reset, active high
//   en             grant enable (in-flight results still return when low)
//   req_valid      per-requester request valid             [NREQ]
//   req_ready      one-hot grant                           [NREQ]
//   req_op         per-requester op, slice i = [2i+1:2i]   [2*NREQ]
//   req_a, req_b   per-requester operands                  [WIDTH*NREQ]
//   alu_op         to ALU op_in                            [2]
//   alu_a, alu_b   to ALU a_in / b_in                      [WIDTH]
//   alu_in_valid   to ALU in_valid
//   alu_out        from ALU out                            [WIDTH]
//   alu_out_valid  from ALU out_valid
//   rsp_valid      one-hot single-cycle result strobe      [NREQ]
//   rsp_data       result data (equals alu_out)            [WIDTH]
//   busy           at least one tag in flight
//   tag_err        sticky: ALU output valid disagreed with the tag pipeline
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 6,
   parameter int LATENCY = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [2*NREQ-1:0]       req_op,
   input  logic [WIDTH*NREQ-1:0]   req_a,
   input  logic [WIDTH*NREQ-1:0]   req_b,
   output logic [1:0]              alu_op,
   output logic [WIDTH-1:0]        alu_a,
   output logic [WIDTH-1:0]        alu_b,
   output logic                    alu_in_valid,
   input  logic [WIDTH-1:0]        alu_out,
   input  logic                    alu_out_valid,
   output logic [NREQ-1:0]         rsp_valid,
   output logic [WIDTH-1:0]        rsp_data,
   output logic                    busy,
   output logic                    tag_err
);

   localparam int IDXW = $clog2(NREQ);

   // ptr + k for k < NREQ never exceeds 2*NREQ-2, which fits in IDXW+1 bits.
   localparam logic [IDXW:0]   NREQ_W = IDXW'(NREQ) == '0 ? {1'b1, {IDXW{1'b0}}}
                                                           : {1'b0, IDXW'(NREQ)};
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

   // ------------------------------------------------------------------------
   // Unpack the flat per-requester buses into arrays
   // ------------------------------------------------------------------------
   logic [1:0]       op_arr [NREQ];
   logic [WIDTH-1:0] a_arr  [NREQ];
   logic [WIDTH-1:0] b_arr  [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign op_arr[gi] = req_op[2*gi +: 2];
         assign a_arr[gi]  = req_a[WIDTH*gi +: WIDTH];
         assign b_arr[gi]  = req_b[WIDTH*gi +: WIDTH];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [IDXW-1:0] ptr_reg, ptr_next;
   logic [LATENCY-1:0] v_reg;             // tag valid per stage, [0] = newest
   logic [IDXW-1:0]    idx_reg [LATENCY]; // tag requester index per stage
   logic               tag_err_reg, tag_err_next;

   logic            grant_any;
   logic [IDXW-1:0] grant_idx;

   // ------------------------------------------------------------------------
   // Round-robin search starting at ptr. The first valid requester found
   // wins; rst forces no grant so nothing is handed to the ALU while the ALU
   // itself is being cleared.
   // ------------------------------------------------------------------------
   always_comb begin
      logic [IDXW:0] cand;
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr_reg} + k[IDXW:0];
         if (cand >= NREQ_W) begin
            cand = cand - NREQ_W;
         end
         if (!grant_any && en && !rst && req_valid[cand[IDXW-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = cand[IDXW-1:0];
         end
      end
   end

   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_ready
         assign req_ready[gi] = grant_any && (grant_idx == IDXW'(gi));
      end
   endgenerate

   // ------------------------------------------------------------------------
   // ALU drive: the granted slice, zeros when idle
   // ------------------------------------------------------------------------
   always_comb begin
      alu_in_valid = grant_any;
      alu_op       = '0;
      alu_a        = '0;
      alu_b        = '0;
      if (grant_any) begin
         alu_op = op_arr[grant_idx];
         alu_a  = a_arr[grant_idx];
         alu_b  = b_arr[grant_idx];
      end
   end

   // ------------------------------------------------------------------------
   // Priority pointer: move just past the winner, hold when idle
   // ------------------------------------------------------------------------
   always_comb begin
      ptr_next = ptr_reg;
      if (grant_any) begin
         ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

   // ------------------------------------------------------------------------
   // Tag pipeline: stage 0 captures {grant, winner} every cycle and all
   // stages shift unconditionally, so the tail lines up with the ALU output.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_reg <= '0;
         for (int s = 0; s < LATENCY; s++) begin
            idx_reg[s] <= '0;
         end
      end else begin
         v_reg[0]   <= grant_any;
         idx_reg[0] <= grant_idx;
         for (int s = 1; s < LATENCY; s++) begin
            v_reg[s]   <= v_reg[s-1];
            idx_reg[s] <= idx_reg[s-1];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Response steering
   // ------------------------------------------------------------------------
   logic            v_tail;
   logic [IDXW-1:0] idx_tail;

   assign v_tail   = v_reg[LATENCY-1];
   assign idx_tail = idx_reg[LATENCY-1];

   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_rsp
         assign rsp_valid[gi] = alu_out_valid && v_tail && (idx_tail == IDXW'(gi));
      end
   endgenerate

   assign rsp_data = alu_out;
   assign busy     = |v_reg;

   // ------------------------------------------------------------------------
   // Sticky tag error: any cycle where the ALU and the tag pipeline disagree
   // on whether a result is present means the two have lost lock-step.
   // ------------------------------------------------------------------------
   assign tag_err_next = tag_err_reg | (alu_out_valid != v_tail);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_err_reg <= 1'b0;
      end else begin
         tag_err_reg <= tag_err_next;
      end
   end

   assign tag_err = tag_err_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter (NREQ=4, WIDTH=6). A behavioural two-stage
// ALU sits next to the arbiter. Inputs change on the falling edge and outputs
// are checked 1 ns later, mid-cycle. "Cycle n" is the interval between the
// n-th and (n+1)-th rising edge counted from the start of each scenario.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 6;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  en;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [2*NREQ-1:0]     req_op;
   logic [WIDTH*NREQ-1:0] req_a;
   logic [WIDTH*NREQ-1:0] req_b;
   logic [1:0]            alu_op;
   logic [WIDTH-1:0]      alu_a;
   logic [WIDTH-1:0]      alu_b;
   logic                  alu_in_valid;
   logic [WIDTH-1:0]      alu_out;
   logic                  alu_out_valid;
   logic [NREQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]      rsp_data;
   logic                  busy;
   logic                  tag_err;

   logic                  force_ov;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LATENCY(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_a         (req_a),
      .req_b         (req_b),
      .alu_op        (alu_op),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_in_valid  (alu_in_valid),
      .alu_out       (alu_out),
      .alu_out_valid (alu_out_valid),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .busy          (busy),
      .tag_err       (tag_err)
   );

   // Behavioural ALU: 2-cycle latency, cleared by the same reset.
   logic             s1_v, o_v;
   logic [WIDTH-1:0] s1_r, o_r;

   function automatic logic [WIDTH-1:0] alu_f(input logic [1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      case (op)
         2'd1:    return a + b;
         2'd2:    return a + ~b + 1'b1;
         default: return '0;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v <= 1'b0;
         s1_r <= '0;
         o_v  <= 1'b0;
         o_r  <= '0;
      end else begin
         s1_v <= alu_in_valid;
         s1_r <= alu_f(alu_op, alu_a, alu_b);
         o_v  <= s1_v;
         o_r  <= s1_r;
      end
   end

   assign alu_out       = o_r;
   assign alu_out_valid = o_v | force_ov;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      #1;
      rst = 1'b0;
   endtask

   task automatic set_req(input int i, input logic [1:0] op,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      req_op[2*i +: 2]         = op;
      req_a[WIDTH*i +: WIDTH]  = a;
      req_b[WIDTH*i +: WIDTH]  = b;
   endtask

   logic [1:0]       op_t [4];
   logic [WIDTH-1:0] a_t  [4];
   logic [WIDTH-1:0] b_t  [4];
   logic [WIDTH-1:0] r_t  [4];

   initial begin
      rst       = 1'b1;
      en        = 1'b1;
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      force_ov  = 1'b0;

      // ---- Reset state: requests present while rst is high ----
      req_valid = 4'hF;
      for (int i = 0; i < NREQ; i++) set_req(i, 2'd1, 6'(i + 1), 6'(i + 2));
      @(negedge clk);
      #1;
      check_val("rst_ready",     req_ready,     0);
      check_val("rst_in_valid",  alu_in_valid,  0);
      check_val("rst_alu_op",    alu_op,        0);
      check_val("rst_alu_a",     alu_a,         0);
      check_val("rst_alu_b",     alu_b,         0);
      check_val("rst_rsp_valid", rsp_valid,     0);
      check_val("rst_busy",      busy,          0);
      check_val("rst_tag_err",   tag_err,       0);

      // ---- Single request: req 2 add 5+7 ----
      rst       = 1'b0;
      req_valid = 4'b0100;
      set_req(2, 2'd1, 6'd5, 6'd7);
      #1;
      check_val("single_c0_ready",    req_ready,    4'b0100);
      check_val("single_c0_in_valid", alu_in_valid, 1);
      check_val("single_c0_alu_op",   alu_op,       1);
      check_val("single_c0_alu_a",    alu_a,        5);
      check_val("single_c0_alu_b",    alu_b,        7);
      check_val("single_c0_busy",     busy,         0);
      next_cycle();
      req_valid = '0;
      #1;
      check_val("single_c1_rsp_valid", rsp_valid, 0);
      check_val("single_c1_busy",      busy,      1);
      next_cycle();
      #1;
      check_val("single_c2_rsp_valid", rsp_valid, 4'b0100);
      check_val("single_c2_rsp_data",  rsp_data,  12);
      check_val("single_c2_busy",      busy,      1);
      next_cycle();
      #1;
      check_val("single_c3_rsp_valid", rsp_valid, 0);
      check_val("single_c3_busy",      busy,      0);

      // ---- Round robin under full load: req i add i+8 ----
      next_cycle();
      pulse_rst();
      for (int i = 0; i < NREQ; i++) set_req(i, 2'd1, 6'(i), 6'd8);
      for (int c = 0; c < 10; c++) begin
         req_valid = (c < 8) ? 4'hF : 4'h0;
         #1;
         if (c < 8) begin
            check_val($sformatf("rr_c%0d_ready", c), req_ready, 1 << (c % 4));
            check_val($sformatf("rr_c%0d_alu_a", c), alu_a,     c % 4);
         end else begin
            check_val($sformatf("rr_c%0d_ready", c), req_ready, 0);
         end
         if (c >= 2) begin
            check_val($sformatf("rr_c%0d_rsp_valid", c), rsp_valid, 1 << ((c - 2) % 4));
            check_val($sformatf("rr_c%0d_rsp_data", c),  rsp_data,  ((c - 2) % 4) + 8);
         end else begin
            check_val($sformatf("rr_c%0d_rsp_valid", c), rsp_valid, 0);
         end
         next_cycle();
      end
      #1;
      check_val("rr_end_busy",    busy,    0);
      check_val("rr_end_tag_err", tag_err, 0);

      // ---- Wrap-around arithmetic, back-to-back from requester 1 ----
      next_cycle();
      pulse_rst();
      op_t = '{2'd1, 2'd2, 2'd0, 2'd3};
      a_t  = '{6'd60, 6'd3, 6'd9, 6'd9};
      b_t  = '{6'd10, 6'd5, 6'd9, 6'd9};
      r_t  = '{6'd6, 6'd62, 6'd0, 6'd0};
      for (int c = 0; c < 6; c++) begin
         if (c < 4) begin
            set_req(1, op_t[c], a_t[c], b_t[c]);
            req_valid = 4'b0010;
         end else begin
            req_valid = '0;
         end
         #1;
         if (c < 4) check_val($sformatf("arith_c%0d_alu_op", c), alu_op, op_t[c]);
         if (c >= 2) begin
            check_val($sformatf("arith_c%0d_rsp_valid", c), rsp_valid, 4'b0010);
            check_val($sformatf("arith_c%0d_rsp_data", c),  rsp_data,  r_t[c-2]);
         end
         next_cycle();
      end

      // ---- Enable gating ----
      pulse_rst();
      set_req(0, 2'd1, 6'd1, 6'd1);
      set_req(1, 2'd1, 6'd2, 6'd2);
      set_req(3, 2'd1, 6'd3, 6'd3);
      for (int c = 0; c < 9; c++) begin
         logic [3:0] exp_rdy, exp_rsp;
         logic [5:0] exp_dat;
         en = !(c >= 2 && c <= 5);
         case (c)
            0:             req_valid = 4'b0011;
            1:             req_valid = 4'b0010;
            2, 3, 4, 5, 6: req_valid = 4'b1000;
            default:       req_valid = 4'b0000;
         endcase
         exp_rdy = (c == 0) ? 4'b0001 : (c == 1) ? 4'b0010 : (c == 6) ? 4'b1000 : 4'b0000;
         exp_rsp = (c == 2) ? 4'b0001 : (c == 3) ? 4'b0010 : (c == 8) ? 4'b1000 : 4'b0000;
         exp_dat = (c == 2) ? 6'd2 : (c == 3) ? 6'd4 : 6'd6;
         #1;
         check_val($sformatf("en_c%0d_ready", c),     req_ready, exp_rdy);
         check_val($sformatf("en_c%0d_rsp_valid", c), rsp_valid, exp_rsp);
         if (exp_rsp != 0) check_val($sformatf("en_c%0d_rsp_data", c), rsp_data, exp_dat);
         next_cycle();
      end
      en = 1'b1;

      // ---- Reset mid-flight ----
      pulse_rst();
      req_valid = 4'b0001;
      #1;
      check_val("mid_c0_ready", req_ready, 4'b0001);
      next_cycle();
      req_valid = 4'b0010;
      #1;
      check_val("mid_c1_ready", req_ready, 4'b0010);
      check_val("mid_c1_busy",  busy,      1);
      #1;
      req_valid = '0;
      rst       = 1'b1;
      #1;
      check_val("mid_in_rst_busy", busy, 0);
      rst = 1'b0;
      next_cycle();
      for (int c = 2; c < 5; c++) begin
         #1;
         check_val($sformatf("mid_c%0d_rsp_valid", c), rsp_valid, 0);
         check_val($sformatf("mid_c%0d_busy", c),      busy,      0);
         check_val($sformatf("mid_c%0d_tag_err", c),   tag_err,   0);
         next_cycle();
      end
      req_valid = 4'hF;
      #1;
      check_val("mid_next_grant", req_ready, 4'b0001);
      next_cycle();
      req_valid = '0;
      for (int c = 0; c < 3; c++) next_cycle();

      // ---- Tag mismatch: spurious ALU output valid ----
      force_ov = 1'b1;
      #1;
      check_val("tag_c0_tag_err",   tag_err,   0);
      check_val("tag_c0_rsp_valid", rsp_valid, 0);
      next_cycle();
      force_ov = 1'b0;
      #1;
      check_val("tag_c1_tag_err",   tag_err,   1);
      check_val("tag_c1_rsp_valid", rsp_valid, 0);
      next_cycle();
      next_cycle();
      #1;
      check_val("tag_c3_tag_err", tag_err, 1);
      pulse_rst();
      #1;
      check_val("tag_after_rst", tag_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
